// File: rtl/wb_burst_responder_pkg.sv
// Shared Wishbone cycle-type codes, burst-type codes and responder FSM states.
package wb_burst_responder_pkg;

  localparam logic [2:0] CTI_CLASSIC   = 3'b000;
  localparam logic [2:0] CTI_INC_BURST = 3'b010;
  localparam logic [2:0] CTI_END_BURST = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  // Low-bit mask of the word index that increments inside a wrapping burst.
  function automatic logic [3:0] bte_wrap_mask(input logic [1:0] bte);
    case (bte)
      BTE_WRAP4:  return 4'h3;
      BTE_WRAP8:  return 4'h7;
      BTE_WRAP16: return 4'hF;
      default:    return 4'hF;
    endcase
  endfunction

  // True when an acked beat with this CTI is followed by another beat.
  // Classic, end-of-burst and reserved codes all finish the cycle.
  function automatic logic cti_continues(input logic [2:0] cti);
    case (cti)
      CTI_INC_BURST:              return 1'b1;
      CTI_CLASSIC, CTI_END_BURST: return 1'b0;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_burst_responder_addr_gen.sv
// Next beat word index for incrementing bursts: linear bursts roll over the
// whole index (modulo DEPTH), wrapping bursts only increment the low bits.
module wb_burst_responder_addr_gen
  import wb_burst_responder_pkg::*;
#(
  parameter int IW = 10
) (
  input  logic [IW-1:0] cur_idx,
  input  logic [1:0]    bte,
  output logic [IW-1:0] nxt_idx
);

  logic [IW-1:0] mask;
  logic [IW-1:0] inc;

  // Increment, then keep the bits outside the wrap window from the current index.
  always_comb begin
    mask    = (bte == BTE_LINEAR) ? {IW{1'b1}} : IW'(bte_wrap_mask(bte));
    inc     = cur_idx + IW'(1);
    nxt_idx = (cur_idx & ~mask) | (inc & mask);
  end

endmodule

// File: rtl/wb_burst_responder.sv
// Wishbone B3 slave responder with word-addressed memory, CTI/BTE bursts,
// programmable initial wait states and ERR for out-of-range start addresses.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_IDLE   | no transfer in progress, waiting for cyc & stb
//   ST_WAIT   | start accepted, counting wait states before the first ack
//   ST_ACTIVE | acking beats; beat_q holds the word of the beat being acked
//   ST_ERR    | err_o high for this single cycle, then back to idle
module wb_burst_responder
  import wb_burst_responder_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int IW  = $clog2(DEPTH);
  localparam int SW  = DW / 8;
  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t         state_q, state_d;
  logic           ack_q, ack_d;
  logic           err_q, err_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [IW-1:0]  beat_q, beat_d;
  logic [IW-1:0]  beat_nxt;
  logic [IW-1:0]  adr_idx;
  logic           in_range;
  logic           req;
  logic [DW-1:0]  mem [DEPTH];
  logic [1:0]     unused_adr_bits;

  assign unused_adr_bits = wb_adr_i[1:0];
  assign adr_idx  = wb_adr_i[IW+1:2];
  assign in_range = (wb_adr_i[AW-1:IW+2] == '0);

  // ack_q is the registered "ready to ack" flag; qualifying it with the live
  // strobe keeps ack low while a burst master inserts wait cycles.
  assign wb_ack_o = ack_q & wb_cyc_i & wb_stb_i;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;
  assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

  // Read straight from the beat register so consecutive beats need no bubble
  // and a word written earlier in the burst is seen immediately.
  assign wb_dat_o = wb_ack_o ? mem[beat_q] : '0;

  wb_burst_responder_addr_gen #(
    .IW(IW)
  ) u_addr_gen (
    .cur_idx (beat_q),
    .bte     (wb_bte_i),
    .nxt_idx (beat_nxt)
  );

  // Next-state, ack/err and beat address decisions.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    err_d   = 1'b0;
    wait_d  = wait_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        ack_d = 1'b0;
        if (req) begin
          if (!in_range) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            beat_d = adr_idx;
            if (WAIT_CYCLES == 0) begin
              state_d = ST_ACTIVE;
              ack_d   = 1'b1;
            end else begin
              state_d = ST_WAIT;
              wait_d  = WAIT_LOAD;
            end
          end
        end
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          state_d = ST_ACTIVE;
          ack_d   = 1'b1;
        end else begin
          wait_d = wait_q - WCW'(1);
        end
      end
      ST_ACTIVE: begin
        if (wb_ack_o) begin
          if (cti_continues(wb_cti_i)) begin
            beat_d = beat_nxt;
          end else begin
            state_d = ST_IDLE;
            ack_d   = 1'b0;
          end
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
      end
    endcase
    if (!wb_cyc_i) begin
      state_d = ST_IDLE;
      ack_d   = 1'b0;
      err_d   = 1'b0;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
    end
  end

  // Byte-lane writes on every acked write beat; contents survive reset.
  always_ff @(posedge wb_clk) begin
    if (wb_ack_o && wb_we_i && !wb_rst) begin
      for (int i = 0; i < SW; i++) begin
        if (wb_sel_i[i]) mem[beat_q][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

endmodule
